// File: rtl/can_crc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : can_crc_pkg
// Purpose  : Shared state encoding, CAN CRC-15 defaults and reference step.
// Revision : 1.0
// ============================================================================
package can_crc_pkg;

    localparam int          CAN_CRC15_W    = 15;
    localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;

    typedef logic [2:0] can_crc_state_t;

    localparam can_crc_state_t ST_IDLE   = 3'd0;
    localparam can_crc_state_t ST_ACCUM  = 3'd1;
    localparam can_crc_state_t ST_TX_OUT = 3'd2;
    localparam can_crc_state_t ST_RX_CHK = 3'd3;
    localparam can_crc_state_t ST_DONE   = 3'd4;

    // One serial step of the classic CAN CRC-15 register.
    function automatic logic [CAN_CRC15_W-1:0] crc_step(
        input logic [CAN_CRC15_W-1:0] r,
        input logic                   b
    );
        logic [CAN_CRC15_W-1:0] t;
        t = {r[CAN_CRC15_W-2:0], 1'b0};
        return (b ^ r[CAN_CRC15_W-1]) ? (t ^ CAN_CRC15_POLY) : t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/can_crc_step_comb.sv
`default_nettype none
// ============================================================================
// Module   : can_crc_step_comb
// Purpose  : Combinational DATA_W-bit CRC advance, MSB of data_in first.
// Revision : 1.0
// ============================================================================
module can_crc_step_comb
    import can_crc_pkg::*;
#(
    parameter int               CRC_W  = CAN_CRC15_W,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CAN_CRC15_POLY),
    parameter int               DATA_W = 1
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [CRC_W-1:0]  crc_out
);

    logic [CRC_W-1:0] w_chain [DATA_W+1];

    assign w_chain[0] = crc_in;

    for (genvar i = 0; i < DATA_W; i++) begin : g_chain
        logic             w_fb;
        logic [CRC_W-1:0] w_shift;

        assign w_fb           = data_in[DATA_W-1-i] ^ w_chain[i][CRC_W-1];
        assign w_shift        = {w_chain[i][CRC_W-2:0], 1'b0};
        assign w_chain[i+1]   = w_fb ? (w_shift ^ POLY) : w_shift;
    end

    assign crc_out = w_chain[DATA_W];

endmodule
`default_nettype wire

// File: rtl/can_crc_engine.sv
`default_nettype none
// ============================================================================
// Module   : can_crc_engine
// Purpose  : CAN CRC generator/checker with serial TX shift-out and RX check.
// Revision : 1.0
// ============================================================================
module can_crc_engine
    import can_crc_pkg::*;
#(
    parameter int               CRC_W  = CAN_CRC15_W,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CAN_CRC15_POLY),
    parameter logic [CRC_W-1:0] INIT   = '0,
    parameter int               DATA_W = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              finish_tx,
    input  logic              finish_rx,
    input  logic              tx_ready,
    output logic [CRC_W-1:0]  crc,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              busy,
    output logic              done,
    output logic              crc_ok,
    output logic              crc_err
);

    localparam int               CNT_W    = $clog2(CRC_W) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CRC_W - 1);

    can_crc_state_t   r_state;
    logic [CRC_W-1:0] r_crc;
    logic [CNT_W-1:0] r_count;
    logic             r_done;
    logic             r_ok;
    logic             r_err;

    logic [CRC_W-1:0] w_accum_next;
    logic [CRC_W-1:0] w_rx_next;
    logic [CRC_W-1:0] w_tx_word;

    can_crc_step_comb #(
        .CRC_W  (CRC_W),
        .POLY   (POLY),
        .DATA_W (DATA_W)
    ) u_accum_step (
        .crc_in  (r_crc),
        .data_in (data_in),
        .crc_out (w_accum_next)
    );

    // The received CRC field arrives one bit per cycle whatever DATA_W is.
    can_crc_step_comb #(
        .CRC_W  (CRC_W),
        .POLY   (POLY),
        .DATA_W (1)
    ) u_rx_step (
        .crc_in  (r_crc),
        .data_in (data_in[0]),
        .crc_out (w_rx_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_crc   <= INIT;
            r_count <= '0;
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_state <= ST_ACCUM;
                r_crc   <= INIT;
                r_count <= '0;
                r_ok    <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                case (r_state)
                    ST_ACCUM: begin
                        if (data_valid) begin
                            r_crc <= w_accum_next;
                        end
                        if (finish_tx) begin
                            r_state <= ST_TX_OUT;
                            r_count <= '0;
                        end else if (finish_rx) begin
                            r_state <= ST_RX_CHK;
                            r_count <= '0;
                        end
                    end
                    ST_TX_OUT: begin
                        if (tx_ready) begin
                            r_count <= r_count + 1'b1;
                            if (r_count == LAST_IDX) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    ST_RX_CHK: begin
                        if (data_valid) begin
                            r_crc   <= w_rx_next;
                            r_count <= r_count + 1'b1;
                            if (r_count == LAST_IDX) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                                r_ok    <= (w_rx_next == '0);
                                r_err   <= (w_rx_next != '0);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Left-shift by the bit index so the bit to send always sits at the MSB.
    assign w_tx_word = r_crc << r_count;

    assign crc      = r_crc;
    assign tx_valid = (r_state == ST_TX_OUT);
    assign tx_bit   = tx_valid & w_tx_word[CRC_W-1];
    assign busy     = (r_state == ST_ACCUM) || (r_state == ST_TX_OUT) ||
                      (r_state == ST_RX_CHK);
    assign done     = r_done;
    assign crc_ok   = r_ok;
    assign crc_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_can_crc_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_crc_engine
// Purpose  : Randomised self-checking bench against a polynomial-division model.
// Revision : 1.0
// ============================================================================
module tb_can_crc_engine;

    localparam logic [14:0] POLY = 15'h4599;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, start, data_in, data_valid, finish_tx, finish_rx, tx_ready;
    logic [14:0] crc;
    logic        tx_bit, tx_valid, busy, done, crc_ok, crc_err;

    logic        start2, dv2;
    logic [1:0]  data_in2;
    logic [14:0] crc2;
    logic        tx_bit2, tx_valid2, busy2, done2, ok2, err2;

    int total = 0;
    int bad   = 0;

    can_crc_engine #(.DATA_W(1)) dut (
        .clock(clock), .reset(reset), .start(start), .data_in(data_in),
        .data_valid(data_valid), .finish_tx(finish_tx), .finish_rx(finish_rx),
        .tx_ready(tx_ready), .crc(crc), .tx_bit(tx_bit), .tx_valid(tx_valid),
        .busy(busy), .done(done), .crc_ok(crc_ok), .crc_err(crc_err)
    );

    can_crc_engine #(.DATA_W(2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .data_in(data_in2),
        .data_valid(dv2), .finish_tx(1'b0), .finish_rx(1'b0),
        .tx_ready(1'b0), .crc(crc2), .tx_bit(tx_bit2), .tx_valid(tx_valid2),
        .busy(busy2), .done(done2), .crc_ok(ok2), .crc_err(err2)
    );

    // Remainder of M(x)*x^15 divided by G(x), by schoolbook long division.
    function automatic logic [14:0] model_crc(input bit msg[$]);
        bit          w[$];
        logic [15:0] g;
        logic [14:0] rem;
        g = {1'b1, POLY};
        w = msg;
        repeat (15) w.push_back(1'b0);
        for (int i = 0; i < msg.size(); i++) begin
            if (w[i]) begin
                for (int j = 0; j < 16; j++) w[i+j] = w[i+j] ^ g[15-j];
            end
        end
        rem = '0;
        for (int k = 0; k < 15; k++) rem[14-k] = w[msg.size()+k];
        return rem;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; data_in = 0; data_valid = 0; finish_tx = 0; finish_rx = 0;
        tx_ready = 0; start2 = 0; dv2 = 0; data_in2 = 0;
    endtask

    task automatic load_msg(input bit msg[$]);
        start = 1; tick(); start = 0;
        foreach (msg[i]) begin
            if ($urandom_range(0, 3) == 0) begin
                data_valid = 0; tick();
            end
            data_in = msg[i]; data_valid = 1; tick();
        end
        data_valid = 0;
    endtask

    task automatic random_msg(output bit msg[$], input int max_len);
        int n;
        msg = {};
        n = $urandom_range(1, max_len);
        for (int i = 0; i < n; i++) msg.push_back(bit'($urandom_range(0, 1)));
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1; start = 1; tick(); reset = 0; start = 0;
        total++;
        if (crc !== 15'h0 || {tx_valid, busy, done, crc_ok, crc_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset crc=%h flags=%b exp crc=0000 flags=00000", crc,
                     {tx_valid, busy, done, crc_ok, crc_err});
        end
        data_in = 1; data_valid = 1; finish_tx = 1; tick();
        data_valid = 0; finish_tx = 0;
        total++;
        if (crc !== 15'h0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_ignore crc=%h busy=%b tx_valid=%b exp 0/0/0", crc, busy, tx_valid);
        end
    endtask

    task automatic test_accum();
        bit          msg[$];
        logic [14:0] exp;
        load_msg('{1'b1});
        total++;
        if (crc !== 15'h4599) begin
            bad++; $display("FAIL accum_first crc=%h exp=4599", crc);
        end
        data_in = 0; data_valid = 1; tick(); data_valid = 0;
        exp = model_crc('{1'b1, 1'b0});
        total++;
        if (crc !== exp || busy !== 1'b1) begin
            bad++; $display("FAIL accum_second crc=%h busy=%b exp=%h busy=1", crc, busy, exp);
        end
        for (int r = 0; r < 4; r++) begin
            random_msg(msg, 40);
            load_msg(msg);
            exp = model_crc(msg);
            total++;
            if (crc !== exp) begin
                bad++; $display("FAIL accum_rand len=%0d crc=%h exp=%h", msg.size(), crc, exp);
            end
        end
    endtask

    task automatic test_data_w2();
        bit          msg[$];
        logic [14:0] exp;
        logic [1:0]  d;
        msg = {};
        start2 = 1; tick(); start2 = 0;
        for (int i = 0; i < 12; i++) begin
            d = (i == 0) ? 2'b10 : 2'($urandom_range(0, 3));
            dv2 = ($urandom_range(0, 3) != 0) || (i == 0);
            data_in2 = d;
            tick();
            if (dv2) begin
                msg.push_back(d[1]);
                msg.push_back(d[0]);
            end
            exp = model_crc(msg);
            total++;
            if (crc2 !== exp) begin
                bad++; $display("FAIL data_w2 step=%0d crc=%h exp=%h", i, crc2, exp);
            end
        end
        dv2 = 0;
    endtask

    task automatic test_tx(input bit msg[$], input int stall_at, input bit rnd_ready);
        logic [14:0] exp;
        int          nbits, ndone, stalls, cyc;
        bit          rdy;
        load_msg(msg);
        exp = model_crc(msg);
        finish_tx = 1; finish_rx = 1; tick(); finish_tx = 0; finish_rx = 0;
        nbits = 0; ndone = 0; stalls = 0; cyc = 0;
        while (nbits < 15 && cyc < 200) begin
            if (rnd_ready) rdy = bit'($urandom_range(0, 1));
            else           rdy = !(nbits == stall_at && stalls < 3);
            if (!rdy) stalls++;
            tx_ready = rdy;
            total++;
            if (tx_valid !== 1'b1 || tx_bit !== exp[14-nbits] || crc !== exp) begin
                bad++;
                $display("FAIL tx_bit idx=%0d valid=%b bit=%b crc=%h exp valid=1 bit=%b crc=%h",
                         nbits, tx_valid, tx_bit, crc, exp[14-nbits], exp);
            end
            tick(); cyc++;
            if (rdy) nbits++;
            if (done) ndone++;
        end
        tx_ready = 0;
        total++;
        if (nbits != 15 || done !== 1'b1 || tx_valid !== 1'b0 || busy !== 1'b0 ||
            crc_ok !== 1'b0 || crc_err !== 1'b0) begin
            bad++;
            $display("FAIL tx_end bits=%0d done=%b valid=%b busy=%b ok=%b err=%b exp 15/1/0/0/0/0",
                     nbits, done, tx_valid, busy, crc_ok, crc_err);
        end
        data_valid = 1; tx_ready = 1;
        repeat (3) begin
            tick();
            if (done) ndone++;
        end
        data_valid = 0; tx_ready = 0;
        total++;
        if (ndone != 1 || crc !== exp) begin
            bad++; $display("FAIL tx_done_pulse count=%0d crc=%h exp count=1 crc=%h", ndone, crc, exp);
        end
    endtask

    task automatic test_rx(input bit msg[$], input bit corrupt);
        logic [14:0] exp, fin;
        bit          all[$];
        int          k, cyc;
        bit          b;
        load_msg(msg);
        exp = model_crc(msg);
        all = msg;
        finish_rx = 1; tick(); finish_rx = 0;
        k = 0; cyc = 0;
        while (k < 15 && cyc < 200) begin
            data_valid = ($urandom_range(0, 2) != 0);
            b = exp[14-k] ^ (corrupt && k == 14);
            data_in = b;
            total++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                bad++; $display("FAIL rx_busy k=%0d done=%b busy=%b exp 0/1", k, done, busy);
            end
            tick(); cyc++;
            if (data_valid) begin
                all.push_back(b);
                k++;
            end
        end
        data_valid = 0;
        fin = model_crc(all);
        total++;
        if (k != 15 || done !== 1'b1 || crc !== fin || crc_ok !== !corrupt || crc_err !== corrupt) begin
            bad++;
            $display("FAIL rx_result bits=%0d done=%b crc=%h ok=%b err=%b exp done=1 crc=%h ok=%b err=%b",
                     k, done, crc, crc_ok, crc_err, fin, !corrupt, corrupt);
        end
        data_in = 1; data_valid = 1; tick(); data_valid = 0;
        total++;
        if (done !== 1'b0 || crc !== fin || crc_ok !== !corrupt || crc_err !== corrupt) begin
            bad++;
            $display("FAIL rx_hold done=%b crc=%h ok=%b err=%b exp done=0 crc=%h ok=%b err=%b",
                     done, crc, crc_ok, crc_err, fin, !corrupt, corrupt);
        end
        start = 1; tick(); start = 0;
        total++;
        if (crc_ok !== 1'b0 || crc_err !== 1'b0 || crc !== 15'h0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rx_restart ok=%b err=%b crc=%h busy=%b exp 0/0/0000/1", crc_ok, crc_err, crc, busy);
        end
    endtask

    task automatic test_reset_mid_tx();
        load_msg('{1'b1});
        finish_tx = 1; tick(); finish_tx = 0;
        tx_ready = 1; repeat (7) tick(); tx_ready = 0;
        total++;
        if (tx_valid !== 1'b1 || tx_bit !== 1'b1) begin
            bad++; $display("FAIL tx_bit7 valid=%b bit=%b exp 1/1", tx_valid, tx_bit);
        end
        reset = 1; tick(); reset = 0;
        total++;
        if (crc !== 15'h0 || {tx_valid, tx_bit, busy, done, crc_ok, crc_err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_mid_tx crc=%h flags=%b exp 0000/000000", crc,
                     {tx_valid, tx_bit, busy, done, crc_ok, crc_err});
        end
        start = 1; finish_rx = 1; finish_tx = 1; tick(); start = 0; finish_rx = 0; finish_tx = 0;
        data_in = 1; data_valid = 1; tick(); data_valid = 0;
        finish_tx = 1; tick(); finish_tx = 0;
        total++;
        if (crc !== 15'h4599 || tx_valid !== 1'b1 || tx_bit !== 1'b1) begin
            bad++;
            $display("FAIL start_priority crc=%h valid=%b bit=%b exp 4599/1/1", crc, tx_valid, tx_bit);
        end
        reset = 1; tick(); reset = 0;
    endtask

    initial begin
        bit msg[$];
        reset = 0;
        clear_inputs();
        repeat (2) tick();
        test_reset();
        test_accum();
        test_data_w2();
        test_tx('{1'b1}, 99, 1'b0);
        test_tx('{1'b1}, 7, 1'b0);
        for (int r = 0; r < 3; r++) begin
            random_msg(msg, 30);
            test_tx(msg, 0, 1'b1);
        end
        test_rx('{1'b1}, 1'b0);
        test_rx('{1'b1}, 1'b1);
        for (int r = 0; r < 3; r++) begin
            random_msg(msg, 30);
            test_rx(msg, bit'(r == 1));
        end
        test_reset_mid_tx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
